// File: rtl/loac_pkg.sv
// Shared definitions for the serial arithmetic blocks: default width and the
// subtractor FSM state encoding.
package loac_pkg;

    localparam int N_Bits_DEFAULT = 8;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} sub_state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the bit-serial subtractor; the master issues
// operands, the slave (the subtractor) returns the difference and flags.
interface serial_subtractor_if import loac_pkg::*; #(
    parameter int N_Bits = N_Bits_DEFAULT
);

    // start is honoured only while the subtractor is idle (busy=0, done=0);
    // done pulses for one cycle and Diff/flags stay valid until the next done.
    logic              start;
    logic [N_Bits-1:0] A1;
    logic [N_Bits-1:0] A2;
    logic              busy;
    logic              done;
    logic [N_Bits-1:0] Diff;
    logic              Zero;
    logic              Negative;
    logic              Par;
    logic              Overflow;

    modport master (
        output start, A1, A2,
        input  busy, done, Diff, Zero, Negative, Par, Overflow
    );

    modport slave (
        input  start, A1, A2,
        output busy, done, Diff, Zero, Negative, Par, Overflow
    );

endinterface

// File: rtl/full_adder_1b.sv
// Single-bit full adder: the only arithmetic cell of the serial datapath.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, Diff = A1 - A2 computed LSB first as
// A1 + ~A2 + 1 through one full-adder cell; result and flags update only on completion.
module serial_subtractor import loac_pkg::*; #(
    parameter int N_Bits = N_Bits_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus,
    output sub_state_t          dbg_state
);

    localparam int CW = (N_Bits > 1) ? $clog2(N_Bits) : 1;
    localparam logic [CW-1:0] LAST_BIT   = CW'(N_Bits - 1);
    localparam logic [CW-1:0] PENULT_BIT = CW'(N_Bits - 2);

    sub_state_t        state_q;
    sub_state_t        state_d;
    logic [N_Bits-1:0] op_a;
    logic [N_Bits-1:0] op_b;
    logic [N_Bits-1:0] res;
    logic [CW-1:0]     cnt;
    logic              carry;
    logic              c_msb_in;
    logic              sum_bit;
    logic              carry_out;
    logic [N_Bits-1:0] sum_full;

    full_adder_1b u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .s    (sum_bit),
        .cout (carry_out)
    );

    // Result as it will look once the current bit is shifted in.
    assign sum_full  = {sum_bit, res[N_Bits-1:1]};
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (cnt == LAST_BIT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == SHIFT);
        bus.done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a         <= '0;
            op_b         <= '0;
            res          <= '0;
            cnt          <= '0;
            carry        <= 1'b0;
            c_msb_in     <= 1'b0;
            bus.Diff     <= '0;
            bus.Zero     <= 1'b0;
            bus.Negative <= 1'b0;
            bus.Par      <= 1'b0;
            bus.Overflow <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.start) begin
                op_a  <= bus.A1;
                op_b  <= ~bus.A2;
                carry <= 1'b1;
                cnt   <= '0;
            end else if (state_q == SHIFT) begin
                res   <= sum_full;
                carry <= carry_out;
                op_a  <= op_a >> 1;
                op_b  <= op_b >> 1;
                cnt   <= cnt + 1'b1;
                if (cnt == PENULT_BIT) c_msb_in <= carry_out;
                // Signed overflow: carry into the sign bit differs from carry out of it.
                if (cnt == LAST_BIT) begin
                    bus.Diff     <= sum_full;
                    bus.Zero     <= (sum_full == '0);
                    bus.Negative <= sum_bit;
                    bus.Par      <= ~sum_full[0];
                    bus.Overflow <= c_msb_in ^ carry_out;
                end
            end
        end
    end

endmodule
